// File: rtl/board_level_frame_receiver.sv
// Serial frame receiver. The line decoder turns framed serial symbols into byte beats.
// The frame assembler collects those beats into frames and presents one frame at a time.

module board_level_data_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       rev_clk,
  input  logic       serial_data,
  output logic       frame_start,
  output logic       frame_end,
  output logic [7:0] data,
  output logic       valid,
  output logic       error
);
  // Symbol on the wire, LSB first: start bit '1', 2-bit code, 8-bit data. The line idles low.
  // An EOF symbol carries the CRC-8 (poly 0x07, init 0) of the payload bytes since SOF.
  typedef enum logic [1:0] {
    CODE_DATA = 2'b00,
    CODE_SOF  = 2'b01,
    CODE_EOF  = 2'b10,
    CODE_RSVD = 2'b11
  } code_e;

  logic [1:0] r_rclk_sync, r_data_sync;
  logic       r_rclk_d, r_busy;
  logic [3:0] r_bit_cnt;
  logic [9:0] r_shift;
  logic [7:0] r_crc;
  logic       w_rise, w_bit;
  logic [9:0] w_sym;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  assign w_rise = r_rclk_sync[1] & ~r_rclk_d;
  assign w_bit  = r_data_sync[1];
  assign w_sym  = {w_bit, r_shift[9:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rclk_sync <= '0;
      r_data_sync <= '0;
      r_rclk_d    <= 1'b0;
      r_busy      <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_crc       <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      data        <= '0;
      valid       <= 1'b0;
      error       <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= only, so every read above sees the pre-edge value.
      valid       <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      error       <= 1'b0;
      r_rclk_sync <= {r_rclk_sync[0], rev_clk};
      r_data_sync <= {r_data_sync[0], serial_data};
      r_rclk_d    <= r_rclk_sync[1];
      if (w_rise) begin
        if (!r_busy) begin
          r_busy    <= w_bit;
          r_bit_cnt <= '0;
        end else begin
          r_shift   <= w_sym;
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd9) begin
            r_busy <= 1'b0;
            data   <= w_sym[9:2];
            case (code_e'(w_sym[1:0]))
              CODE_SOF: begin
                valid       <= 1'b1;
                frame_start <= 1'b1;
                r_crc       <= '0;
              end
              CODE_DATA: begin
                valid <= 1'b1;
                r_crc <= crc8_step(r_crc, w_sym[9:2]);
              end
              CODE_EOF: begin
                valid     <= 1'b1;
                frame_end <= 1'b1;
                error     <= (w_sym[9:2] != r_crc);
              end
              default: ;
            endcase
          end
        end
      end
    end
  end
endmodule

module board_level_frame_receiver #(
  parameter int MAX_BYTE_N  = 8,
  parameter int MIN_BYTE_N  = 1,
  parameter int DROP_ERRORS = 0,
  parameter int STAT_W      = 16,
  localparam int LEN_W      = $clog2(MAX_BYTE_N + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rev_clk,
  input  logic                    serial_data,
  output logic [MAX_BYTE_N*8-1:0] out_data,
  output logic [LEN_W-1:0]        out_length,
  output logic                    out_data_error,
  output logic                    out_length_error,
  output logic                    out_error,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clr_stats,
  output logic [STAT_W-1:0]       frame_cnt,
  output logic [STAT_W-1:0]       err_cnt,
  output logic [STAT_W-1:0]       drop_cnt
);
  typedef enum logic {IDLE, RECV} state_e;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTE_N);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_BYTE_N);
  localparam logic [LEN_W-1:0] SAT_L = LEN_W'(MAX_BYTE_N + 1);

  logic                    w_start, w_end, w_valid, w_err;
  logic [7:0]              w_data;
  logic                    w_done, w_len_err, w_errored, w_can, w_keep, w_commit, w_drop;
  logic [LEN_W-1:0]        w_len;
  state_e                  r_state;
  logic [LEN_W-1:0]        r_cnt;
  logic [MAX_BYTE_N*8-1:0] r_buf;

  board_level_data_receiver u_rx (
    .clk         (clk),
    .rst         (rst),
    .rev_clk     (rev_clk),
    .serial_data (serial_data),
    .frame_start (w_start),
    .frame_end   (w_end),
    .data        (w_data),
    .valid       (w_valid),
    .error       (w_err)
  );

  assign w_done    = w_valid && !w_start && w_end && (r_state == RECV);
  assign w_len_err = (r_cnt < MIN_L) || (r_cnt > MAX_L);
  assign w_len     = (r_cnt > MAX_L) ? MAX_L : r_cnt;
  assign w_errored = w_err || w_len_err;
  // With DROP_ERRORS an errored frame is silently discarded: no commit and no drop count.
  assign w_keep    = !((DROP_ERRORS != 0) && w_errored);
  assign w_can     = !out_valid || out_ready;
  assign w_commit  = w_done && w_keep && w_can;
  assign w_drop    = w_done && w_keep && !w_can;
  assign out_error = out_data_error || out_length_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_buf            <= '0;
      out_data         <= '0;
      out_length       <= '0;
      out_data_error   <= 1'b0;
      // NOTE: a zero length is always below the minimum, so the empty slot reports a length error.
      out_length_error <= 1'b1;
      out_valid        <= 1'b0;
      frame_cnt        <= '0;
      err_cnt          <= '0;
      drop_cnt         <= '0;
    end else begin
      if (w_valid) begin
        if (w_start) begin
          r_state <= RECV;
          r_cnt   <= '0;
          r_buf   <= '0;
        end else if (r_state == RECV) begin
          if (w_end) begin
            r_state <= IDLE;
          end else begin
            if (r_cnt < MAX_L) r_buf[8*int'(r_cnt) +: 8] <= w_data;
            if (r_cnt != SAT_L) r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      if (w_commit) begin
        out_data         <= r_buf;
        out_length       <= w_len;
        out_data_error   <= w_err;
        out_length_error <= w_len_err;
        out_valid        <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr_stats) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
        drop_cnt  <= '0;
      end else begin
        if (w_done && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
        if (w_done && w_errored && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (w_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_board_level_frame_receiver.sv
// Directed bench: serial frames into two receivers (errors presented / errors dropped),
// checked against hand-computed payloads, lengths, flags and counters.

module tb_board_level_frame_receiver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rev_clk = 1'b0;
  logic        serial_data = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_stats = 1'b0;

  logic [63:0] out_data, d_out_data;
  logic [3:0]  out_length, d_out_length;
  logic        out_data_error, out_length_error, out_error, out_valid;
  logic        d_out_data_error, d_out_length_error, d_out_error, d_out_valid;
  logic [15:0] frame_cnt, err_cnt, drop_cnt, d_frame_cnt, d_err_cnt, d_drop_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int vcyc = 0, xfer = 0, xfer_d = 0;
  int vcyc0, xfer0, xferd0;
  logic [63:0] cap_data;
  logic [3:0]  cap_len;
  logic        cap_derr, cap_lerr, cap_err;
  logic [7:0]  pay [16];

  always #5 clk = ~clk;

  board_level_frame_receiver #(.MAX_BYTE_N(8), .MIN_BYTE_N(1), .DROP_ERRORS(0), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .rev_clk(rev_clk), .serial_data(serial_data),
    .out_data(out_data), .out_length(out_length), .out_data_error(out_data_error),
    .out_length_error(out_length_error), .out_error(out_error), .out_valid(out_valid),
    .out_ready(out_ready), .clr_stats(clr_stats),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  board_level_frame_receiver #(.MAX_BYTE_N(8), .MIN_BYTE_N(1), .DROP_ERRORS(1), .STAT_W(16)) dut_d (
    .clk(clk), .rst(rst), .rev_clk(rev_clk), .serial_data(serial_data),
    .out_data(d_out_data), .out_length(d_out_length), .out_data_error(d_out_data_error),
    .out_length_error(d_out_length_error), .out_error(d_out_error), .out_valid(d_out_valid),
    .out_ready(out_ready), .clr_stats(clr_stats),
    .frame_cnt(d_frame_cnt), .err_cnt(d_err_cnt), .drop_cnt(d_drop_cnt)
  );

  always @(posedge clk) begin
    if (out_valid) vcyc++;
    if (out_valid && out_ready) begin
      xfer++;
      cap_data = out_data;
      cap_len  = out_length;
      cap_derr = out_data_error;
      cap_lerr = out_length_error;
      cap_err  = out_error;
    end
    if (d_out_valid && out_ready) xfer_d++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    serial_data = b;
    #40 rev_clk = 1'b1;
    #40 rev_clk = 1'b0;
  endtask

  // code: 0 data, 1 SOF, 2 EOF
  task automatic send_sym(input logic [1:0] code, input logic [7:0] d);
    send_bit(1'b1);
    send_bit(code[0]);
    send_bit(code[1]);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
  endtask

  function automatic logic [7:0] crc_of(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ pay[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic send_frame(input int n, input logic bad_crc);
    send_sym(2'd1, 8'h00);
    for (int i = 0; i < n; i++) send_sym(2'd0, pay[i]);
    send_sym(2'd2, crc_of(n) ^ (bad_crc ? 8'hFF : 8'h00));
    repeat (20) @(negedge clk);
  endtask

  task automatic clear_and_mark();
    @(negedge clk) clr_stats = 1'b1;
    @(negedge clk) clr_stats = 1'b0;
    vcyc0 = vcyc; xfer0 = xfer; xferd0 = xfer_d;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_len", out_length, 0);
    check("rst_len_err", out_length_error, 1);
    check("rst_err", out_error, 1);
    check("rst_frame_cnt", frame_cnt, 0);

    // Good 4-byte frame
    clear_and_mark();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_frame(4, 1'b0);
    check("good_vcyc", vcyc - vcyc0, 1);
    check("good_data", cap_data, 64'h0000_0000_4433_2211);
    check("good_len", cap_len, 4);
    check("good_err", cap_err, 0);
    check("good_frame_cnt", frame_cnt, 1);
    check("good_valid_after", out_valid, 0);

    // Stray end beat while idle
    send_sym(2'd2, 8'h00);
    repeat (20) @(negedge clk);
    check("idle_end_frame_cnt", frame_cnt, 1);
    check("idle_end_vcyc", vcyc - vcyc0, 1);

    // 10-byte frame, truncated to 8
    clear_and_mark();
    check("clr_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
    send_frame(10, 1'b0);
    check("long_xfer", xfer - xfer0, 1);
    check("long_data", cap_data, 64'h0807_0605_0403_0201);
    check("long_len", cap_len, 8);
    check("long_len_err", cap_lerr, 1);
    check("long_err_cnt", err_cnt, 1);

    // 3-byte frame with bad CRC
    clear_and_mark();
    pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hC3;
    send_frame(3, 1'b1);
    check("crc_xfer", xfer - xfer0, 1);
    check("crc_data_err", cap_derr, 1);
    check("crc_len", cap_len, 3);
    check("crc_data", cap_data, 64'h0000_0000_00C3_C2C1);
    check("crc_drop_xfer", xfer_d - xferd0, 0);
    check("crc_drop_vcyc_now", d_out_valid, 0);
    check("crc_drop_err_cnt", d_err_cnt, 1);
    check("crc_drop_drop_cnt", d_drop_cnt, 0);
    check("crc_drop_frame_cnt", d_frame_cnt, 1);

    // Backpressure: A held, B dropped
    out_ready = 1'b0;
    clear_and_mark();
    pay[0] = 8'hAA;
    send_frame(1, 1'b0);
    check("bp_a_valid", out_valid, 1);
    check("bp_a_data", out_data, 64'hAA);
    pay[0] = 8'hBB;
    send_frame(1, 1'b0);
    check("bp_hold_data", out_data, 64'hAA);
    check("bp_hold_len", out_length, 1);
    check("bp_hold_valid", out_valid, 1);
    check("bp_drop_cnt", drop_cnt, 1);
    check("bp_frame_cnt", frame_cnt, 2);
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    check("bp_fall", out_valid, 0);
    repeat (20) @(negedge clk);
    check("bp_xfer", xfer - xfer0, 1);
    check("bp_xfer_data", cap_data, 64'hAA);
    check("bp_no_b", out_valid, 0);
    out_ready = 1'b1;

    // Restart mid-frame
    clear_and_mark();
    send_sym(2'd1, 8'h00);
    send_sym(2'd0, 8'h55);
    send_sym(2'd0, 8'h66);
    pay[0] = 8'h77;
    send_frame(1, 1'b0);
    check("restart_xfer", xfer - xfer0, 1);
    check("restart_len", cap_len, 1);
    check("restart_data", cap_data, 64'h77);
    check("restart_frame_cnt", frame_cnt, 1);

    // Reset in the middle of a frame
    send_sym(2'd1, 8'h00);
    send_sym(2'd0, 8'h12);
    send_sym(2'd0, 8'h34);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_len", out_length, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    xfer0 = xfer;
    pay[0] = 8'h99;
    send_frame(1, 1'b0);
    check("post_rst_xfer", xfer - xfer0, 1);
    check("post_rst_len", cap_len, 1);
    check("post_rst_data", cap_data, 64'h99);
    check("post_rst_frame_cnt", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/board_level_frame_receiver.md
BOARD_LEVEL_FRAME_RECEIVER -- requirements
Module: board_level_frame_receiver

Interface
REQ-001 Parameter MAX_BYTE_N, 8: maximum payload bytes stored per frame; must be at least 1.
REQ-002 Parameter MIN_BYTE_N, 1: minimum legal payload bytes; must be between 1 and MAX_BYTE_N.
REQ-003 Parameter DROP_ERRORS, 0: when 1, frames with a CRC or length error are counted but never presented.
REQ-004 Parameter STAT_W, 16: width of each statistics counter.
REQ-005 Port clk, input, 1: system clock. One clock only. Reset is synchronous and active-high.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port rev_clk, input, 1: receive clock from the transmitter.
REQ-008 Port serial_data, input, 1: serial data from the transmitter.
REQ-009 Port out_data, output, MAX_BYTE_N*8: frame payload; byte k sits at bits [8k+7:8k].
REQ-010 Port out_length, output, LEN_W = clog2(MAX_BYTE_N+2): payload byte count, clamped to MAX_BYTE_N.
REQ-011 Port out_data_error, output, 1: CRC error flag of the presented frame.
REQ-012 Port out_length_error, output, 1: set when the received count is below MIN_BYTE_N or above MAX_BYTE_N.
REQ-013 Port out_error, output, 1: OR of out_data_error and out_length_error.
REQ-014 Port out_valid, output, 1: the output slot holds a frame.
REQ-015 Port out_ready, input, 1: consumer accepts the frame.
REQ-016 Port clr_stats, input, 1: synchronously clears all statistics counters.
REQ-017 Ports frame_cnt, err_cnt and drop_cnt, outputs, STAT_W each: saturating statistics counters.

Function
REQ-018 The block shall instantiate board_level_data_receiver on clk, rst, rev_clk and serial_data to obtain byte beats: frame_start, frame_end, data[7:0], valid and error.
REQ-019 The FSM shall have two states, IDLE and RECV; only beats with valid=1 affect it.
- Any beat with frame_start goes to RECV from either state; a start during RECV aborts the current frame.
- In RECV, a beat with frame_end goes to IDLE.
REQ-020 Start beats and end beats shall carry no payload; every other valid beat in RECV is a payload byte.
REQ-021 On a start beat, the byte counter and the assembly buffer shall clear to zero.
REQ-022 Each payload byte shall be written at index = counter while counter < MAX_BYTE_N; bytes beyond that are discarded.
REQ-023 The counter shall saturate at MAX_BYTE_N+1.
REQ-024 The end beat shall complete the frame, capturing the error signal of that beat as the CRC status.
REQ-025 Completion shall commit length = min(counter, MAX_BYTE_N), the length error, the CRC status and the buffer to the output slot.
- The slot is updated and out_valid=1 on the clock after the end beat.
- Unwritten upper bytes read as zero.
REQ-026 A commit shall be permitted when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (back-to-back transfer).
REQ-027 Otherwise, the completed frame shall be dropped, drop_cnt shall increment, and the slot shall stay unchanged.
REQ-028 While out_valid=1 and out_ready=0, all out_* signals shall hold stable.
REQ-029 out_valid shall fall the cycle after out_valid=1 and out_ready=1, unless a commit happens in that same cycle.
REQ-030 With DROP_ERRORS=1, an errored completion shall not commit and shall not increment drop_cnt.
REQ-031 frame_cnt shall increment on every completion, err_cnt on every errored completion, and drop_cnt as given in REQ-027.
- All counters saturate at 2^STAT_W-1.
- clr_stats has priority over an increment in the same cycle.
REQ-032 An end beat received in IDLE shall be ignored, with no counting.

Reset
REQ-033 rst shall force IDLE and zero the counter and buffer.
REQ-034 rst shall drive out_valid=0 and out_data, out_length, out_data_error and all statistics counters to 0.
REQ-035 With out_length=0, out_length_error shall read 1.
REQ-036 A frame in progress at reset shall be discarded; reception resumes at the next start beat.

Verification (MAX_BYTE_N=8, MIN_BYTE_N=1, out_ready=1 unless stated)
REQ-037 Good 4-byte frame 11,22,33,44.
- Expect out_valid=1 for one cycle, out_data=0x...0044332211 with the upper 32 bits zero, out_length=4, out_error=0, frame_cnt=1.
REQ-038 10-byte frame 01..0A.
- Expect out_data=0x0807060504030201, out_length=8, out_length_error=1, err_cnt=1.
REQ-039 3-byte frame with bad CRC.
- DROP_ERRORS=0: expect out_data_error=1 and out_valid=1.
- DROP_ERRORS=1: expect no out_valid, err_cnt=1, drop_cnt=0.
REQ-040 out_ready=0; send frames A (AA) and then B (BB).
- Expect A held stable and drop_cnt=1.
- Raising out_ready for one cycle transfers A; out_valid then falls; B never appears.
REQ-041 Start beat, bytes 55,66, second start beat, byte 77, end beat.
- Expect out_length=1 and out_data[7:0]=0x77; frame_cnt=1.
REQ-042 rst asserted after 2 bytes, then a good 1-byte frame 99.
- Expect outputs 0 during reset, then one frame with out_length=1 and out_data[7:0]=0x99.
